mini_src_control_unit: RTL
==========================

// Module: mini_src_control_unit
// PURPOSE
//  Hardwired Moore control sequencer for the Mini-SRC datapath. It is the driving end of the ALU interface:
//  it produces the ALU opcode and IncPC strobes, plus bus-source, register-load and memory strobes.
//  Sequencing: fetch T0-T2, then per-class execute steps T3-T7, then back to T0. Supports halt/stop.
// PARAMETERS
//  IR_W      32    instruction register width; opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
//  LINK_REG  15    register written by jal
// PORTS
//  clock      in   1   system clock, rising edge
//  clear_n    in   1   asynchronous, active-low reset
//  ir         in   32  current IR contents from datapath
//  stop       in   1   external halt request
//  alu_op     out  5   opcode to ALU (ALU encoding: add 00011, branch 10011, etc.)
//  inc_pc     out  1   ALU IncPC select
//  src_sel    out  4   bus source: 0 none,1 PC,2 MDR,3 ZLO,4 ZHI,5 HI,6 LO,7 INPORT,8 C(sign-ext imm),9 Rout,10 BAout
//  ld         out  11  one-hot loads: [0]PCin [1]IRin [2]MARin [3]MDRin [4]Yin [5]Zin [6]HIin [7]LOin [8]CONin [9]OUTin [10]Rin
//  reg_sel    out  2   register field: 0 none,1 Ra,2 Rb,3 Rc
//  link       out  1   force register select to LINK_REG (overrides reg_sel)
//  mem_rd     out  1   memory read strobe (MDR loads from memory when set with ld[3])
//  mem_wr     out  1   memory write strobe
//  run        out  1   1 while executing; 0 in RESET/HALT
//  illegal    out  1   sticky undefined-opcode flag (ILLEGAL_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (clear_n=0, any time, including mid-instruction): enter RESET. All outputs 0, run=0.
//    First rising edge after release -> T0, run=1.
//  - Outputs are a pure decode of state (RESET/HALT/T0..T7) and ir. Unlisted outputs are 0 in every step.
//    alu_op=ir[31:27] in all exec steps unless stated.
//  - Fetch: T0 src=PC,MARin,inc_pc,Zin | T1 src=ZLO,PCin,mem_rd,MDRin | T2 src=MDR,IRin.
//  - Execute:
//    - R-ALU (add,sub,shr,shra,shl,ror,rol,and,or): T3 Rb Rout Yin | T4 Rc Rout Zin | T5 ZLO Ra Rin.
//    - neg/not: T3 Rb Rout Zin | T4 ZLO Ra Rin.
//    - mul/div: T3 Ra Rout Yin | T4 Rb Rout Zin | T5 ZLO LOin | T6 ZHI HIin.
//    - addi/andi/ori/ldi: T3 Rb BAout Yin | T4 C Zin | T5 ZLO Ra Rin. ldi forces alu_op=add.
//    - ld: T3-T4 as ldi | T5 ZLO MARin | T6 mem_rd MDRin | T7 MDR Ra Rin.
//    - st: T3-T5 as ld | T6 Ra Rout MDRin | T7 mem_wr.
//    - branch: T3 Ra Rout CONin | T4 PC Yin | T5 C Zin, alu_op=10011 | T6 ZLO PCin.
//      Taken/not-taken is resolved in the ALU from CON FF; the sequence is identical for both.
//    - jr: T3 Ra Rout PCin.  jal: T3 PC link Rin | T4 Ra Rout PCin.
//    - in: T3 INPORT Ra Rin. out: T3 Ra Rout OUTin. mfhi: T3 HI Ra Rin. mflo: T3 LO Ra Rin.
//    - nop (11010): last step is T2.  halt (11011): T2 -> HALT.
//  - After an instruction's last step the next state is T0, unless stop=1 is sampled on that edge, in which
//    case -> HALT. stop is sampled only at instruction boundaries, so in-flight instructions always complete.
//  - HALT: all strobes 0, run=0. HALT is left only via clear_n.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: an undefined opcode (11100-11111, excluding nop/halt) at T2 -> HALT; illegal set to 1
//    and held until clear_n.
//  ILLEGAL_TRAP_EN undefined: undefined opcodes execute as nop; illegal is constant 0.
// TESTING
//  1. Pulse clear_n low during T4 of add -> same cycle all outputs 0, run=0; release -> next edge T0:
//     src_sel=1, ld=0x024, inc_pc=1.
//  2. ir=0x1A920000 (add R5,R2,R4) -> 6 cycles; T3 reg_sel=2 Yin; T4 reg_sel=3 alu_op=00011 Zin;
//     T5 src_sel=3 reg_sel=1 Rin; then T0.
//  3. mul (op 01111) -> 7 cycles; T5 src_sel=3 ld=0x080; T6 src_sel=4 ld=0x040.
//  4. branch (op 10011) with CON FF 0 and 1 -> T5 alu_op=10011 Zin, T6 PCin in both cases; 7 cycles each.
//  5. ld (op 00000) -> 8 cycles; mem_rd in T1 and T6; T7 src_sel=2 Rin. st -> mem_wr only in T7.
//  6. Halt and stop:
//     - halt opcode 11011 -> run=0 from cycle after T2, held for 20 cycles.
//     - stop=1 during T4 of add -> add completes, run=0 after T5.
//     - opcode 11100 -> illegal=1 with ILLEGAL_TRAP_EN; without it, returns to T0 after T2.

Source files
------------

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control sequencer for the Mini-SRC datapath: fetch T0-T2, per-class execute T3-T7.
// Optional feature macro ILLEGAL_TRAP_EN: undefined opcodes halt the sequencer and raise a sticky flag.
module mini_src_control_unit #(
  parameter int IR_W     = 32,
  parameter int LINK_REG = 15
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic [IR_W-1:0] ir,
  input  logic            stop,
  output logic [4:0]      alu_op,
  output logic            inc_pc,
  output logic [3:0]      src_sel,
  output logic [10:0]     ld,
  output logic [1:0]      reg_sel,
  output logic            link,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            run,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_HALT = 4'd1,
    S_T0 = 4'd2, S_T1 = 4'd3, S_T2 = 4'd4, S_T3 = 4'd5,
    S_T4 = 4'd6, S_T5 = 4'd7, S_T6 = 4'd8, S_T7 = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_RALU = 4'd0, C_UNARY = 4'd1, C_MULDIV = 4'd2, C_IMM = 4'd3,
    C_LD = 4'd4, C_ST = 4'd5, C_BR = 4'd6, C_JR = 4'd7,
    C_JAL = 4'd8, C_IN = 4'd9, C_OUT = 4'd10, C_MFHI = 4'd11,
    C_MFLO = 4'd12, C_NOP = 4'd13, C_HALT = 4'd14, C_UNDEF = 4'd15
  } class_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_BR  = 5'b10011;

  localparam logic [3:0] SRC_NONE = 4'd0, SRC_PC = 4'd1, SRC_MDR = 4'd2, SRC_ZLO = 4'd3;
  localparam logic [3:0] SRC_ZHI = 4'd4, SRC_HI = 4'd5, SRC_LO = 4'd6, SRC_INP = 4'd7;
  localparam logic [3:0] SRC_C = 4'd8, SRC_ROUT = 4'd9, SRC_BA = 4'd10;

  localparam logic [10:0] LD_PC  = 11'h001, LD_IR = 11'h002, LD_MAR = 11'h004, LD_MDR = 11'h008;
  localparam logic [10:0] LD_Y   = 11'h010, LD_Z  = 11'h020, LD_HI  = 11'h040, LD_LO  = 11'h080;
  localparam logic [10:0] LD_CON = 11'h100, LD_OUT = 11'h200, LD_R  = 11'h400;

  localparam logic [1:0] RS_NONE = 2'd0, RS_RA = 2'd1, RS_RB = 2'd2, RS_RC = 2'd3;

  state_t     state_r;
  state_t     state_nx_s;
  state_t     last_s;
  class_t     cls_s;
  logic [4:0] opcode_s;
  logic       trap_s;
  logic       unused_s;

  assign opcode_s = ir[IR_W-1 -: 5];
  // Register fields are consumed by the datapath; LINK_REG is resolved there as well.
  assign unused_s = ^{ir[IR_W-6:0], 4'(LINK_REG)};

`ifdef ILLEGAL_TRAP_EN
  assign trap_s = (cls_s == C_UNDEF);
`else
  assign trap_s = 1'b0;
`endif

  // Opcode to instruction class
  always_comb begin
    cls_s = C_UNDEF;
    case (opcode_s)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: cls_s = C_RALU;
      5'd17, 5'd18:                      cls_s = C_UNARY;
      5'd15, 5'd16:                      cls_s = C_MULDIV;
      5'd1, 5'd12, 5'd13, 5'd14:         cls_s = C_IMM;
      5'd0:                              cls_s = C_LD;
      5'd2:                              cls_s = C_ST;
      5'd19:                             cls_s = C_BR;
      5'd20:                             cls_s = C_JR;
      5'd21:                             cls_s = C_JAL;
      5'd22:                             cls_s = C_IN;
      5'd23:                             cls_s = C_OUT;
      5'd24:                             cls_s = C_MFHI;
      5'd25:                             cls_s = C_MFLO;
      5'd26:                             cls_s = C_NOP;
      5'd27:                             cls_s = C_HALT;
      default:                           cls_s = C_UNDEF;
    endcase
  end

  // Final step of each instruction class
  always_comb begin
    last_s = S_T2;
    case (cls_s)
      C_RALU, C_IMM:            last_s = S_T5;
      C_UNARY, C_JAL:           last_s = S_T4;
      C_MULDIV, C_BR:           last_s = S_T6;
      C_LD, C_ST:               last_s = S_T7;
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: last_s = S_T3;
      default:                  last_s = S_T2;
    endcase
  end

  // Next-state: stop is only honoured on an instruction boundary
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_RESET: state_nx_s = S_T0;
      S_HALT:  state_nx_s = S_HALT;
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_r == last_s) begin
          if ((cls_s == C_HALT) || trap_s || stop) begin
            state_nx_s = S_HALT;
          end else begin
            state_nx_s = S_T0;
          end
        end else begin
          state_nx_s = state_t'(state_r + 4'd1);
        end
      end
      default: state_nx_s = S_RESET;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state_r <= S_RESET;
    else          state_r <= state_nx_s;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky undefined-opcode flag, cleared only by reset
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)                          illegal_r <= 1'b0;
    else if ((state_r == S_T2) && trap_s)  illegal_r <= 1'b1;
  end

  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  // Moore output decode of state and instruction class
  always_comb begin
    alu_op  = 5'd0;
    inc_pc  = 1'b0;
    src_sel = SRC_NONE;
    ld      = 11'd0;
    reg_sel = RS_NONE;
    link    = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    run     = 1'b1;
    case (state_r)
      S_T0: begin src_sel = SRC_PC;  ld = LD_MAR | LD_Z;  inc_pc = 1'b1; end
      S_T1: begin src_sel = SRC_ZLO; ld = LD_PC | LD_MDR; mem_rd = 1'b1; end
      S_T2: begin src_sel = SRC_MDR; ld = LD_IR; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        alu_op = opcode_s;
        case (cls_s)
          C_RALU: begin
            case (state_r)
              S_T3:    begin src_sel = SRC_ROUT; reg_sel = RS_RB; ld = LD_Y; end
              S_T4:    begin src_sel = SRC_ROUT; reg_sel = RS_RC; ld = LD_Z; end
              S_T5:    begin src_sel = SRC_ZLO;  reg_sel = RS_RA; ld = LD_R; end
              default: begin end
            endcase
          end
          C_UNARY: begin
            case (state_r)
              S_T3:    begin src_sel = SRC_ROUT; reg_sel = RS_RB; ld = LD_Z; end
              S_T4:    begin src_sel = SRC_ZLO;  reg_sel = RS_RA; ld = LD_R; end
              default: begin end
            endcase
          end
          C_MULDIV: begin
            case (state_r)
              S_T3:    begin src_sel = SRC_ROUT; reg_sel = RS_RA; ld = LD_Y; end
              S_T4:    begin src_sel = SRC_ROUT; reg_sel = RS_RB; ld = LD_Z; end
              S_T5:    begin src_sel = SRC_ZLO;  ld = LD_LO; end
              S_T6:    begin src_sel = SRC_ZHI;  ld = LD_HI; end
              default: begin end
            endcase
          end
          C_IMM: begin
            if (opcode_s == OP_LDI) alu_op = OP_ADD;
            else                    alu_op = opcode_s;
            case (state_r)
              S_T3:    begin src_sel = SRC_BA;  reg_sel = RS_RB; ld = LD_Y; end
              S_T4:    begin src_sel = SRC_C;   ld = LD_Z; end
              S_T5:    begin src_sel = SRC_ZLO; reg_sel = RS_RA; ld = LD_R; end
              default: begin end
            endcase
          end
          C_LD, C_ST: begin
            // Effective address Rb + C is formed exactly like ldi
            case (state_r)
              S_T3:    begin alu_op = OP_ADD; src_sel = SRC_BA; reg_sel = RS_RB; ld = LD_Y; end
              S_T4:    begin alu_op = OP_ADD; src_sel = SRC_C;  ld = LD_Z; end
              S_T5:    begin src_sel = SRC_ZLO; ld = LD_MAR; end
              S_T6: begin
                if (cls_s == C_LD) begin mem_rd = 1'b1; ld = LD_MDR; end
                else begin src_sel = SRC_ROUT; reg_sel = RS_RA; ld = LD_MDR; end
              end
              S_T7: begin
                if (cls_s == C_LD) begin src_sel = SRC_MDR; reg_sel = RS_RA; ld = LD_R; end
                else begin mem_wr = 1'b1; end
              end
              default: begin end
            endcase
          end
          C_BR: begin
            case (state_r)
              S_T3:    begin src_sel = SRC_ROUT; reg_sel = RS_RA; ld = LD_CON; end
              S_T4:    begin src_sel = SRC_PC;  ld = LD_Y; end
              S_T5:    begin src_sel = SRC_C;   ld = LD_Z; alu_op = OP_BR; end
              S_T6:    begin src_sel = SRC_ZLO; ld = LD_PC; end
              default: begin end
            endcase
          end
          C_JR:   begin src_sel = SRC_ROUT; reg_sel = RS_RA; ld = LD_PC; end
          C_JAL: begin
            case (state_r)
              S_T3:    begin src_sel = SRC_PC; link = 1'b1; ld = LD_R; end
              S_T4:    begin src_sel = SRC_ROUT; reg_sel = RS_RA; ld = LD_PC; end
              default: begin end
            endcase
          end
          C_IN:   begin src_sel = SRC_INP;  reg_sel = RS_RA; ld = LD_R; end
          C_OUT:  begin src_sel = SRC_ROUT; reg_sel = RS_RA; ld = LD_OUT; end
          C_MFHI: begin src_sel = SRC_HI;   reg_sel = RS_RA; ld = LD_R; end
          C_MFLO: begin src_sel = SRC_LO;   reg_sel = RS_RA; ld = LD_R; end
          default: begin end
        endcase
      end
      default: run = 1'b0;
    endcase
  end

endmodule
